// File: rtl/dsp_frame_accumulator.sv
// dsp_frame_accumulator
//   Sums a programmable number of signed DSP products into one frame result,
//   rounds (half toward +inf) and saturates it to OUT_W bits, and presents it
//   through a single-entry valid/ready output register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous clear of frame state, output and flags
//   p_in, p_valid         signed sample from the DSP stage (no backpressure)
//   frame_len             samples per frame, captured at first sample (0 -> 1)
//   out_data, out_valid   rounded/saturated frame result, held until accepted
//   out_ready             downstream accept
//   sat_flag              out_data was clamped (same timing as out_data)
//   ovf                   sticky: a completed frame was dropped (output full)
module dsp_frame_accumulator #(
    parameter int unsigned IN_W  = 48,
    parameter int unsigned ACC_W = 56,
    parameter int unsigned OUT_W = 18,
    parameter int unsigned SHIFT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [IN_W-1:0]  p_in,
    input  logic             p_valid,
    input  logic [7:0]       frame_len,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic             ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0]        RND     = ACC_W'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]                count_q, count_d;
    logic [7:0]                len_q, len_d;

    logic signed [ACC_W-1:0]   p_ext;
    logic                      frame_done;
    logic signed [ACC_W-1:0]   frame_sum;
    logic signed [ACC_W-1:0]   rnd_sum;
    logic signed [ACC_W-1:0]   r_sh;
    logic [OUT_W-1:0]          res_data;
    logic                      res_sat;

    assign p_ext = {{(ACC_W-IN_W){p_in[IN_W-1]}}, p_in};

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // Next-state: frame accumulation and completion detect
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        len_d      = len_q;
        frame_done = 1'b0;
        frame_sum  = acc_q + p_ext;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            len_d   = '0;
        end else if (p_valid) begin
            case (state_q)
                IDLE: begin
                    len_d = (frame_len == 8'd0) ? 8'd1 : frame_len;
                    if (len_d == 8'd1) begin
                        // single-sample frame completes immediately
                        frame_done = 1'b1;
                        frame_sum  = p_ext;
                    end else begin
                        acc_d   = p_ext;
                        count_d = 8'd1;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (count_q == len_q - 8'd1) begin
                        frame_done = 1'b1;
                        acc_d      = '0;
                        count_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        acc_d   = frame_sum;
                        count_d = count_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Round half toward +inf, arithmetic shift, then clamp to OUT_W
    assign rnd_sum = frame_sum + RND;
    assign r_sh    = rnd_sum >>> SHIFT;

    always_comb begin
        res_data = r_sh[OUT_W-1:0];
        res_sat  = 1'b0;
        if (r_sh > SAT_MAX) begin
            res_data = OUT_MAX;
            res_sat  = 1'b1;
        end else if (r_sh < SAT_MIN) begin
            res_data = OUT_MIN;
            res_sat  = 1'b1;
        end
    end

    // Single-entry output register; a result arriving while full and stalled is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            ovf       <= 1'b0;
        end else if (clear) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            ovf       <= 1'b0;
        end else if (frame_done) begin
            if (!out_valid || out_ready) begin
                out_data  <= res_data;
                sat_flag  <= res_sat;
                out_valid <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_frame_accumulator.sv
// tb_dsp_frame_accumulator
//   Directed-vector bench for dsp_frame_accumulator with hand-computed results.
module tb_dsp_frame_accumulator;

    localparam int unsigned IN_W  = 48;
    localparam int unsigned OUT_W = 18;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [IN_W-1:0]  p_in;
    logic             p_valid;
    logic [7:0]       frame_len;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sat_flag;
    logic             ovf;

    int checks;
    int errors;

    dsp_frame_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .frame_len (frame_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one clock edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] v);
        p_in    = v;
        p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        p_in      = '0;
        p_valid   = 1'b0;
        frame_len = 8'd4;
        out_ready = 1'b1;
        idle(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_sat",   64'(sat_flag),  64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: four samples of 1.0 -> 4
        frame_len = 8'd4;
        send(48'h10000); send(48'h10000); send(48'h10000);
        check("t1_early_valid", 64'(out_valid), 64'd0);
        send(48'h10000);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data",  64'(out_data),  64'd4);
        check("t1_sat",   64'(sat_flag),  64'd0);
        idle(1);
        check("t1_drop_valid", 64'(out_valid), 64'd0);

        // 2: single-sample frames exercising the rounding boundary
        frame_len = 8'd1;
        send(48'd32768);
        check("t2_d0", 64'(out_data), 64'd1);
        send(48'd32767);
        check("t2_d1", 64'(out_data), 64'd0);
        send(-48'sd32768);
        check("t2_d2", 64'(out_data), 64'd0);
        send(-48'sd32769);
        check("t2_d3", 64'(out_data), 64'(18'h3FFFF));
        check("t2_valid", 64'(out_valid), 64'd1);
        idle(1);

        // frame_len of 0 behaves as 1
        frame_len = 8'd0;
        send(48'h30000);
        check("len0_valid", 64'(out_valid), 64'd1);
        check("len0_data",  64'(out_data),  64'd3);
        idle(1);

        // 3: saturation both directions
        frame_len = 8'd2;
        send(48'h100_0000_0000); send(48'h100_0000_0000);
        check("t3_pos_data", 64'(out_data), 64'(18'h1FFFF));
        check("t3_pos_sat",  64'(sat_flag), 64'd1);
        send(-48'sh100_0000_0000); send(-48'sh100_0000_0000);
        check("t3_neg_data", 64'(out_data), 64'(18'h20000));
        check("t3_neg_sat",  64'(sat_flag), 64'd1);
        idle(1);

        // 4: backpressure drops the second frame and sets ovf
        out_ready = 1'b0;
        send(48'h10000); send(48'h10000);
        check("t4_valid1", 64'(out_valid), 64'd1);
        check("t4_data1",  64'(out_data),  64'd2);
        check("t4_sat1",   64'(sat_flag),  64'd0);
        check("t4_ovf0",   64'(ovf),       64'd0);
        send(48'h20000); send(48'h20000);
        check("t4_held_data", 64'(out_data), 64'd2);
        check("t4_ovf1",      64'(ovf),      64'd1);
        out_ready = 1'b1;
        tick();
        check("t4_accepted", 64'(out_valid), 64'd0);
        check("t4_ovf_sticky", 64'(ovf), 64'd1);
        do_clear();
        check("t4_ovf_clr", 64'(ovf), 64'd0);

        // 5: gaps between samples do not change the result
        frame_len = 8'd3;
        send(48'h10000); idle(2);
        send(48'h10000); idle(2);
        check("t5_gap_valid", 64'(out_valid), 64'd0);
        send(48'h10000);
        check("t5_valid", 64'(out_valid), 64'd1);
        check("t5_data",  64'(out_data),  64'd3);
        idle(1);

        // 6: reset mid-frame discards the partial sum and a held result
        out_ready = 1'b0;
        frame_len = 8'd1;
        send(48'h10000);
        check("t6_held", 64'(out_valid), 64'd1);
        frame_len = 8'd4;
        send(48'h10000); send(48'h10000);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        send(48'h10000); send(48'h10000);
        check("t6_part_valid", 64'(out_valid), 64'd0);
        send(48'h10000); send(48'h10000);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_data",  64'(out_data),  64'd4);
        idle(1);

        // clear beats p_valid: the sample is not counted
        frame_len = 8'd2;
        p_in    = 48'h10000;
        p_valid = 1'b1;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        p_valid = 1'b0;
        send(48'h10000);
        check("clr_ignored", 64'(out_valid), 64'd0);
        send(48'h10000);
        check("clr_valid", 64'(out_valid), 64'd1);
        check("clr_data",  64'(out_data),  64'd2);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
